// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with dp, blanking, leading-zero suppression.
// Latency: seg_out/dp_out/an_out registered, one cycle after scan state/shadow; load visible on outputs two edges later.
// Backpressure: none; free-running scan, load captured unconditionally on the edge it is high.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   value_in        packed hex nibbles, nibble i = digit i (0 = rightmost)
//   dp_in/blank_in  per-digit decimal point request / force-dark
//   load            capture value_in/dp_in/blank_in into shadow registers
//   lz_en           leading-zero suppression enable (live, not shadowed)
//   seg_out[0:6]    segments a..g, dp_out decimal point, an_out digit enables
//   digit_idx       digit index of the current scan slot
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
   localparam int DIV_W = $clog2(REFRESH_DIV)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    load,
   input  logic                    lz_en,
   output logic [0:6]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic [IDX_W-1:0]        digit_idx
);

   logic [4*NUM_DIGITS-1:0] shadow_val;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [NUM_DIGITS-1:0]   shadow_blank;
   logic [DIV_W-1:0]        div_cnt;
   logic [IDX_W-1:0]        scan_idx;

   logic [NUM_DIGITS-1:0]   lz_sup;
   logic [3:0]              cur_nib;
   logic [0:6]              nxt_seg;
   logic                    nxt_dp;
   logic [NUM_DIGITS-1:0]   nxt_an;

   // Active-high segment pattern (a..g, bit 0 = a) for a hex nibble.
   function automatic logic [0:6] glyph_lit(input logic [3:0] nib);
      logic [0:6] low;
      case (nib)
         4'h0:    low = 7'b0000001;
         4'h1:    low = 7'b1001111;
         4'h2:    low = 7'b0010010;
         4'h3:    low = 7'b0000110;
         4'h4:    low = 7'b1001100;
         4'h5:    low = 7'b0100100;
         4'h6:    low = 7'b0100000;
         4'h7:    low = 7'b0001111;
         4'h8:    low = 7'b0000000;
         4'h9:    low = 7'b0000100;
         4'hA:    low = 7'b0001000;
         4'hB:    low = 7'b1100000;
         4'hC:    low = 7'b0110001;
         4'hD:    low = 7'b1000010;
         4'hE:    low = 7'b0110000;
         default: low = 7'b0111000;
      endcase
      return ~low;
   endfunction

   // Shadow registers
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_val   <= '0;
         shadow_dp    <= '0;
         shadow_blank <= '0;
      end else if (load) begin
         shadow_val   <= value_in;
         shadow_dp    <= dp_in;
         shadow_blank <= blank_in;
      end
   end

   // Refresh divider and digit scan counter
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         scan_idx <= '0;
      end else if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
         div_cnt  <= '0;
         scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         div_cnt  <= div_cnt + 1'b1;
      end
   end

   // Digit i is a leading zero when every nibble from the top down to i is zero.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      lz_sup     = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above & (shadow_val[4*i +: 4] == 4'h0);
         lz_sup[i]  = (i > 0) && zero_above;
      end
   end

   assign cur_nib = shadow_val[4*scan_idx +: 4];

   // div_cnt==0 is the anti-ghost guard cycle: everything dark while anodes switch.
   always_comb begin
      nxt_an  = '0;
      nxt_seg = '0;
      nxt_dp  = 1'b0;
      if (div_cnt != '0) begin
         nxt_an[scan_idx] = 1'b1;
         if (!shadow_blank[scan_idx]) begin
            nxt_dp = shadow_dp[scan_idx];
            if (!(lz_en && lz_sup[scan_idx]))
               nxt_seg = glyph_lit(cur_nib);
         end
      end
   end

   // Output stage: the only place polarity is applied.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_out <= SEG_ACTIVE_LOW ? '1 : '0;
         dp_out  <= SEG_ACTIVE_LOW;
         an_out  <= AN_ACTIVE_LOW ? '1 : '0;
      end else begin
         seg_out <= SEG_ACTIVE_LOW ? ~nxt_seg : nxt_seg;
         dp_out  <= SEG_ACTIVE_LOW ? ~nxt_dp  : nxt_dp;
         an_out  <= AN_ACTIVE_LOW  ? ~nxt_an  : nxt_an;
      end
   end

   assign digit_idx = scan_idx;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, 4-cycle slots, active-low outputs).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_seven_seg_scan_driver;

   localparam int ND = 4;
   localparam int RD = 4;

   localparam logic [6:0] G0   = 7'b0000001;
   localparam logic [6:0] G1   = 7'b1001111;
   localparam logic [6:0] G2   = 7'b0010010;
   localparam logic [6:0] G4   = 7'b1001100;
   localparam logic [6:0] GA   = 7'b0001000;
   localparam logic [6:0] GF   = 7'b0111000;
   localparam logic [6:0] DARK = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic        load = 1'b0;
   logic        lz_en = 1'b0;
   logic [0:6]  seg_out;
   logic        dp_out;
   logic [3:0]  an_out;
   logic [1:0]  digit_idx;

   int checks = 0;
   int failures = 0;
   int m_div = 0, m_idx = 0, pre_div = 0, pre_idx = 0;
   logic [6:0] exp_seg [4];
   logic [3:0] exp_dpo;
   int an_cnt [4];

   seven_seg_scan_driver #(
      .NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
      .load(load), .lz_en(lz_en), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out),
      .digit_idx(digit_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; the bench keeps its own divider/scan position.
   task automatic step();
      pre_div = m_div;
      pre_idx = m_idx;
      @(posedge clk);
      if (rst) begin
         m_div = 0;
         m_idx = 0;
      end else if (m_div == RD - 1) begin
         m_div = 0;
         m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
      end else begin
         m_div = m_div + 1;
      end
      #1;
   endtask

   task automatic step_check();
      logic [3:0] ea;
      step();
      check("digit_idx", 32'(digit_idx), 32'(m_idx));
      for (int i = 0; i < ND; i++)
         if (an_out[i] == 1'b0) an_cnt[i]++;
      if (pre_div == 0) begin
         check("guard_an", 32'(an_out), 32'hF);
         check("guard_seg", 32'(seg_out), 32'(DARK));
         check("guard_dp", 32'(dp_out), 32'h1);
      end else begin
         ea = 4'hF;
         ea[pre_idx] = 1'b0;
         check("an", 32'(an_out), 32'(ea));
         check("seg", 32'(seg_out), 32'(exp_seg[pre_idx]));
         check("dp", 32'(dp_out), 32'(exp_dpo[pre_idx]));
      end
   endtask

   task automatic set_tab(input logic [6:0] s3, input logic [6:0] s2,
                          input logic [6:0] s1, input logic [6:0] s0,
                          input logic [3:0] dpo);
      exp_seg[3] = s3;
      exp_seg[2] = s2;
      exp_seg[1] = s1;
      exp_seg[0] = s0;
      exp_dpo    = dpo;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_an"}, 32'(an_out), 32'hF);
      check({tag, "_seg"}, 32'(seg_out), 32'(DARK));
      check({tag, "_dp"}, 32'(dp_out), 32'h1);
      check({tag, "_idx"}, 32'(digit_idx), 32'h0);
   endtask

   // The load edge still shows the old shadow; the new table applies from the next edge.
   task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
      value_in = v;
      dp_in    = dp;
      blank_in = bl;
      load     = 1'b1;
      step_check();
      load     = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < ND; i++) an_cnt[i] = 0;

      // 1: reset held three cycles, then first slot opens with a guard cycle
      repeat (3) step();
      check_reset_vals("reset");
      rst = 1'b0;
      set_tab(G0, G0, G0, G0, 4'hF);
      step_check();
      step_check();
      repeat (14) step_check();

      // 2: plain hex display
      do_load(16'h12AF, 4'h0, 4'h0);
      set_tab(G1, G2, GA, GF, 4'hF);
      repeat (16) step_check();

      // 3: leading-zero suppression
      lz_en = 1'b1;
      do_load(16'h0040, 4'h0, 4'h0);
      set_tab(DARK, DARK, G4, G0, 4'hF);
      repeat (16) step_check();
      do_load(16'h0000, 4'h0, 4'h0);
      set_tab(DARK, DARK, DARK, G0, 4'hF);
      repeat (16) step_check();

      // 4: dp survives suppression, blanking kills it
      do_load(16'h0000, 4'b1000, 4'h0);
      set_tab(DARK, DARK, DARK, G0, 4'b0111);
      repeat (16) step_check();
      do_load(16'h0000, 4'b1000, 4'b1000);
      set_tab(DARK, DARK, DARK, G0, 4'hF);
      repeat (16) step_check();

      // 5: lz_en is live; mid-slot load; then rst wins over load
      lz_en = 1'b0;
      set_tab(DARK, G0, G0, G0, 4'hF);
      for (int k = 0; k < 8 && m_div != 2; k++) step_check();
      check("sync_div2", 32'(m_div), 32'd2);
      do_load(16'h1111, 4'h0, 4'h0);
      set_tab(G1, G1, G1, G1, 4'hF);
      repeat (16) step_check();

      rst      = 1'b1;
      load     = 1'b1;
      value_in = 16'hFFFF;
      dp_in    = 4'hF;
      step();
      rst  = 1'b0;
      load = 1'b0;
      check_reset_vals("rst_load");
      set_tab(G0, G0, G0, G0, 4'hF);
      repeat (16) step_check();

      // 6: three full scans, each anode lit RD-1 cycles per scan
      for (int i = 0; i < ND; i++) an_cnt[i] = 0;
      repeat (3 * ND * RD) step_check();
      for (int i = 0; i < ND; i++)
         check($sformatf("an_cnt%0d", i), 32'(an_cnt[i]), 32'(3 * (RD - 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
